// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sharing one full-adder cell, LSB first, with a start/busy/done handshake.
// Defining SERIAL_ADD_SUB_EN adds the sub_i port for two's-complement A-B.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             sub_sel;
  logic             cell_s;
  logic             cell_c;
  logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub_i;
`else
  assign sub_sel = 1'b0;
`endif

  // The single shared full-adder cell.
  assign cell_s   = a_sh[0] ^ b_sh[0] ^ carry_q;
  assign cell_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_sh    <= a_i;
            b_sh    <= sub_sel ? ~b_i : b_i;
            carry_q <= sub_sel;
            cnt     <= '0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
            busy_o  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_o   <= {cell_s, sum_o[WIDTH-1:1]};
          carry_q <= cell_c;
          if (last_bit) begin
            // Flags are registered here so they are valid in the same cycle as done_o;
            // carry_q at this point is the carry into the MSB.
            cout_o <= cell_c;
            ovf_o  <= carry_q ^ cell_c;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
